// File: rtl/mdio_multi_master.sv
// mdio_multi_master
//   Clause-22 MDIO master driving NUM_CHANNELS independent MDIO buses from a
//   single shared frame engine. One command is in flight at a time; the
//   command's channel selects which bus carries the frame. Idle buses are held
//   with MDC low, the output driver disabled and the drive value high.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_channel/write/phy_addr/
//                       reg_addr/wr_data are the command payload
//   rsp_valid           one-cycle completion pulse with rsp_channel,
//                       rsp_error (channel out of range) and rsp_rd_data
//   chan_busy           one bit per bus, high while that bus carries a frame
//   mdc, mdio_tx_data,  per-bus MDC, pad drive value and pad output enable
//   mdio_tx_en
//   mdio_rx_data        per-bus pad input, already synchronised to clk
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is only high in IDLE, drops on the cycle
// after a transfer and returns on the cycle after the rsp_valid pulse.
// rsp_valid has no back-pressure. While cmd_ready is low, cmd_* is ignored.
module mdio_multi_master #(
  parameter int NUM_CHANNELS  = 3,
  parameter int CLK_DIV       = 75,
  parameter int PREAMBLE_BITS = 32,
  parameter int GATE_CYCLES   = 1048575,
  localparam int CHAN_BITS    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CHAN_BITS-1:0]    cmd_channel,
  input  logic                    cmd_write,
  input  logic [4:0]              cmd_phy_addr,
  input  logic [4:0]              cmd_reg_addr,
  input  logic [15:0]             cmd_wr_data,
  output logic                    rsp_valid,
  output logic [CHAN_BITS-1:0]    rsp_channel,
  output logic                    rsp_error,
  output logic [15:0]             rsp_rd_data,
  output logic [NUM_CHANNELS-1:0] chan_busy,
  output logic [NUM_CHANNELS-1:0] mdc,
  output logic [NUM_CHANNELS-1:0] mdio_tx_data,
  output logic [NUM_CHANNELS-1:0] mdio_tx_en,
  input  logic [NUM_CHANNELS-1:0] mdio_rx_data
);

  localparam int FRAME_BITS = PREAMBLE_BITS + 32;
  localparam int HALF       = CLK_DIV / 2;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int GATE_W     = $clog2(GATE_CYCLES + 1);
  localparam int BIT_W      = 6;
  // A read releases the bus after REGAD; TA and DATA come from the PHY.
  localparam int RD_EN_BITS = PREAMBLE_BITS + 14;
  localparam int DATA_START = PREAMBLE_BITS + 16;

  typedef enum logic [1:0] {GATE, IDLE, FRAME, DONE} state_t;

  state_t                  state_q, state_d;
  logic [GATE_W-1:0]       gate_q, gate_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [CHAN_BITS-1:0]    ch_q, ch_d;
  logic                    wr_q, wr_d;
  logic [4:0]              phy_q, phy_d;
  logic [4:0]              reg_q, reg_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [15:0]             rd_sh_q, rd_sh_d;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [CHAN_BITS-1:0]    rsp_channel_q, rsp_channel_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [15:0]             rsp_rd_data_q, rsp_rd_data_d;
  logic [NUM_CHANNELS-1:0] chan_busy_q, chan_busy_d;
  logic [NUM_CHANNELS-1:0] mdc_q, mdc_d;
  logic [NUM_CHANNELS-1:0] tx_data_q, tx_data_d;
  logic [NUM_CHANNELS-1:0] tx_en_q, tx_en_d;

  logic [NUM_CHANNELS-1:0] sel_q, sel_d;
  logic                    rx_bit;
  logic [31:0]             body;
  int                      body_off;
  logic                    bit_val;
  logic                    in_frame;

  // One-hot channel selects for the latched (current) and next command.
  always_comb begin
    sel_q = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sel_q[i] = (ch_q == CHAN_BITS'(i));
      sel_d[i] = (ch_d == CHAN_BITS'(i));
    end
  end

  assign rx_bit = |(mdio_rx_data & sel_q);

  // Control path: FSM, counters and command latch.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    wr_d    = wr_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd_sh_d = rd_sh_q;
    case (state_q)
      GATE: begin
        if (gate_q == GATE_W'(GATE_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gate_d = gate_q + 1'b1;
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ch_d    = cmd_channel;
          wr_d    = cmd_write;
          phy_d   = cmd_phy_addr;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wr_data;
          rd_sh_d = '0;
          div_d   = '0;
          bit_d   = '0;
          if (32'(cmd_channel) >= 32'(NUM_CHANNELS)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = FRAME;
          end
        end
      end
      FRAME: begin
        // Sample the PHY on the cycle MDC has just risen.
        if (!wr_q && (div_q == DIV_W'(HALF)) && (bit_q >= BIT_W'(DATA_START))) begin
          rd_sh_d = {rd_sh_q[14:0], rx_bit};
        end
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = GATE;
      end
    endcase
  end

  // Serial bit for the next cycle. Positions after the preamble index the
  // 32-bit ST..DATA body; TA and DATA of a read are undriven so their drive
  // value is left high.
  always_comb begin
    body     = {2'b01, (wr_d ? 2'b01 : 2'b10), phy_d, reg_d,
                (wr_d ? 2'b10 : 2'b11), (wr_d ? wdata_d : 16'hFFFF)};
    body_off = int'(bit_d) - PREAMBLE_BITS;
    bit_val  = 1'b1;
    if (body_off >= 0) begin
      bit_val = body[5'(31 - body_off)];
    end
  end

  // Registered outputs are computed from next-state values so they line up
  // with the state they describe.
  always_comb begin
    in_frame      = (state_d == FRAME);
    cmd_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == DONE);
    rsp_error_d   = (state_d == DONE) && err_d;
    rsp_channel_d = (state_d == DONE) ? ch_d : '0;
    rsp_rd_data_d = ((state_d == DONE) && !err_d && !wr_d) ? rd_sh_d : 16'h0000;
    chan_busy_d   = '0;
    mdc_d         = '0;
    tx_en_d       = '0;
    tx_data_d     = '1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (in_frame && sel_d[i]) begin
        chan_busy_d[i] = 1'b1;
        mdc_d[i]       = (div_d >= DIV_W'(HALF));
        tx_en_d[i]     = wr_d || (bit_d < BIT_W'(RD_EN_BITS));
        tx_data_d[i]   = bit_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= GATE;
      gate_q        <= '0;
      div_q         <= '0;
      bit_q         <= '0;
      ch_q          <= '0;
      wr_q          <= 1'b0;
      phy_q         <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      rd_sh_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_channel_q <= '0;
      rsp_error_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      chan_busy_q   <= '0;
      mdc_q         <= '0;
      tx_data_q     <= '1;
      tx_en_q       <= '0;
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      ch_q          <= ch_d;
      wr_q          <= wr_d;
      phy_q         <= phy_d;
      reg_q         <= reg_d;
      wdata_q       <= wdata_d;
      err_q         <= err_d;
      rd_sh_q       <= rd_sh_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_channel_q <= rsp_channel_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      chan_busy_q   <= chan_busy_d;
      mdc_q         <= mdc_d;
      tx_data_q     <= tx_data_d;
      tx_en_q       <= tx_en_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_channel  = rsp_channel_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_rd_data  = rsp_rd_data_q;
  assign chan_busy    = chan_busy_q;
  assign mdc          = mdc_q;
  assign mdio_tx_data = tx_data_q;
  assign mdio_tx_en   = tx_en_q;

endmodule

// File: tb/tb_mdio_multi_master.sv
// Bench for mdio_multi_master. dut1: 3 buses, CLK_DIV=8, 32-bit preamble,
// 16 gate cycles. dut2: 3 buses, CLK_DIV=5, no preamble, 4 gate cycles.
module tb_mdio_multi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // dut1 signals
  logic        c1_valid = 1'b0, c1_ready, c1_wr = 1'b0;
  logic [1:0]  c1_ch = '0;
  logic [4:0]  c1_phy = '0, c1_reg = '0;
  logic [15:0] c1_wd = '0;
  logic        r1_valid, r1_err;
  logic [1:0]  r1_ch;
  logic [15:0] r1_rd;
  logic [2:0]  busy1, mdc1, txd1, txe1;
  logic [2:0]  rx1 = '0;
  // dut2 signals
  logic        c2_valid = 1'b0, c2_ready, c2_wr = 1'b0;
  logic [1:0]  c2_ch = '0;
  logic [4:0]  c2_phy = '0, c2_reg = '0;
  logic [15:0] c2_wd = '0;
  logic        r2_valid, r2_err;
  logic [1:0]  r2_ch;
  logic [15:0] r2_rd;
  logic [2:0]  busy2, mdc2, txd2, txe2;
  logic [2:0]  rx2 = '0;

  mdio_multi_master #(.NUM_CHANNELS(3), .CLK_DIV(8), .PREAMBLE_BITS(32), .GATE_CYCLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_channel(c1_ch), .cmd_write(c1_wr), .cmd_phy_addr(c1_phy), .cmd_reg_addr(c1_reg),
    .cmd_wr_data(c1_wd), .rsp_valid(r1_valid), .rsp_channel(r1_ch), .rsp_error(r1_err),
    .rsp_rd_data(r1_rd), .chan_busy(busy1), .mdc(mdc1), .mdio_tx_data(txd1),
    .mdio_tx_en(txe1), .mdio_rx_data(rx1));

  mdio_multi_master #(.NUM_CHANNELS(3), .CLK_DIV(5), .PREAMBLE_BITS(0), .GATE_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_channel(c2_ch), .cmd_write(c2_wr), .cmd_phy_addr(c2_phy), .cmd_reg_addr(c2_reg),
    .cmd_wr_data(c2_wd), .rsp_valid(r2_valid), .rsp_channel(r2_ch), .rsp_error(r2_err),
    .rsp_rd_data(r2_rd), .chan_busy(busy2), .mdc(mdc2), .mdio_tx_data(txd2),
    .mdio_tx_en(txe2), .mdio_rx_data(rx2));

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus monitors and PHY read models ----------------
  logic [1:0]  cap1_q[$];   // {tx_en, tx_data} at each MDC rise on the busy bus
  logic [1:0]  exp_q[$];
  int          edges1[3] = '{0, 0, 0};
  int          rsp_cnt1 = 0;
  logic [2:0]  mdc1_prev = '0, busy1_prev = '0;
  logic [15:0] rx1_word = '0;
  logic [2:0]  mdc2_prev = '0, busy2_prev = '0;
  int          cap2_n = 0;
  logic [15:0] rx2_word = '0;

  always @(negedge clk) begin
    if (busy1 != 3'b000 && busy1_prev == 3'b000) cap1_q.delete();
    if (r1_valid) rsp_cnt1++;
    for (int i = 0; i < 3; i++) begin
      if (mdc1[i] && !mdc1_prev[i]) begin
        edges1[i]++;
        if (busy1[i]) begin
          int k;
          cap1_q.push_back({txe1[i], txd1[i]});
          k = cap1_q.size() - 1;
          if (k >= 48 && k < 64) rx1[i] = rx1_word[15 - (k - 48)];
        end
      end
    end
    mdc1_prev  = mdc1;
    busy1_prev = busy1;
  end

  always @(negedge clk) begin
    if (busy2 != 3'b000 && busy2_prev == 3'b000) cap2_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mdc2[i] && !mdc2_prev[i] && busy2[i]) begin
        if (cap2_n >= 16 && cap2_n < 32) rx2[i] = rx2_word[15 - (cap2_n - 16)];
        cap2_n++;
      end
    end
    mdc2_prev  = mdc2;
    busy2_prev = busy2;
  end

  // ---------------- driver tasks ----------------
  logic [1:0]  s_ch;
  logic        s_err;
  logic [15:0] s_rd;

  task automatic drive_cmd(input int which, input logic [1:0] ch, input logic wr,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = 0;
    if (which == 0) begin
      c1_ch = ch; c1_wr = wr; c1_phy = phy; c1_reg = rg; c1_wd = wd; c1_valid = 1'b1;
    end else begin
      c2_ch = ch; c2_wr = wr; c2_phy = phy; c2_reg = rg; c2_wd = wd; c2_valid = 1'b1;
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (((which == 0) ? c1_ready : c2_ready) === 1'b1) begin
        ok = 1'b1;
        t_acc = cyc;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    c1_valid = 1'b0;
    c2_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int which, output int t_rsp, output bit ok);
    ok = 1'b0;
    t_rsp = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (((which == 0) ? r1_valid : r2_valid) === 1'b1) begin
        ok = 1'b1;
        t_rsp = cyc;
        s_ch  = (which == 0) ? r1_ch : r2_ch;
        s_err = (which == 0) ? r1_err : r2_err;
        s_rd  = (which == 0) ? r1_rd : r2_rd;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_gate();
    int c0, k, ready_bad, mdc_bad;
    c1_ch = 2'd3; c1_wr = 1'b1; c1_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({c1_ready, r1_valid, r1_err, r1_ch, r1_rd} !== 21'h0) begin
      bad++; $display("FAIL reset_cmd_rsp: got %h required 0", {c1_ready, r1_valid, r1_err, r1_ch, r1_rd});
    end
    total++;
    if ({busy1, mdc1, txe1, txd1} !== 12'b000_000_000_111) begin
      bad++; $display("FAIL reset_bus: got %b required 000000000111", {busy1, mdc1, txe1, txd1});
    end
    rst_n = 1'b1;
    c0 = cyc;
    ready_bad = 0;
    mdc_bad = 0;
    do begin
      @(negedge clk);
      k = cyc - c0;
      if (c1_ready !== (k >= 16)) ready_bad++;
      if (mdc1 !== 3'b000) mdc_bad++;
    end while (k < 16);
    total++;
    if (ready_bad != 0) begin
      bad++; $display("FAIL gate_ready: wrong cycles=%0d required 0", ready_bad);
    end
    total++;
    if (mdc_bad != 0) begin
      bad++; $display("FAIL gate_mdc: cycles with mdc high=%0d required 0", mdc_bad);
    end
    @(posedge clk);
    #1 c1_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({r1_valid, r1_err, r1_ch, r1_rd} !== {1'b1, 1'b1, 2'd3, 16'h0}) begin
      bad++; $display("FAIL gate_accept_rsp: got %h required %h", {r1_valid, r1_err, r1_ch, r1_rd}, {1'b1, 1'b1, 2'd3, 16'h0});
    end
  endtask

  task automatic check_stream(input string name, input int care_bits);
    int mism, first;
    total++;
    if (cap1_q.size() != 64) begin
      bad++; $display("FAIL %s_len: got %0d bits required 64", name, cap1_q.size());
    end
    mism = 0;
    first = -1;
    for (int i = 0; i < 64 && i < cap1_q.size(); i++) begin
      if (i < care_bits ? (cap1_q[i] !== exp_q[i]) : (cap1_q[i][1] !== 1'b0)) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (mism != 0) begin
      bad++; $display("FAIL %s_bits: %0d wrong bits, first at %0d got %b required %b", name, mism, first, cap1_q[first], exp_q[first]);
    end
  endtask

  task automatic test_write();
    int t_acc, t_rsp, e[3];
    bit ok1, ok2;
    logic [31:0] body = 32'b01_01_00011_00000_10_0001000101000000;
    e = edges1;
    drive_cmd(0, 2'd1, 1'b1, 5'h03, 5'h00, 16'h1140, t_acc, ok1);
    @(negedge clk);
    total++;
    if (c1_ready !== 1'b0) begin
      bad++; $display("FAIL write_ready_drop: got %b required 0", c1_ready);
    end
    repeat (100) @(negedge clk);
    total++;
    if (busy1 !== 3'b010) begin
      bad++; $display("FAIL write_busy: got %b required 010", busy1);
    end
    wait_rsp(0, t_rsp, ok2);
    total++;
    if (!(ok1 && ok2) || (t_rsp - t_acc) != 513) begin
      bad++; $display("FAIL write_latency: got %0d (ok %b%b) required 513", t_rsp - t_acc, ok1, ok2);
    end
    total++;
    if ({s_ch, s_err, s_rd} !== {2'd1, 1'b0, 16'h0}) begin
      bad++; $display("FAIL write_rsp: got %h required %h", {s_ch, s_err, s_rd}, {2'd1, 1'b0, 16'h0});
    end
    @(negedge clk);
    total++;
    if (r1_valid !== 1'b0) begin
      bad++; $display("FAIL write_rsp_pulse: got %b required 0", r1_valid);
    end
    total++;
    if ((edges1[0] - e[0]) != 0 || (edges1[2] - e[2]) != 0 || (edges1[1] - e[1]) != 64) begin
      bad++; $display("FAIL write_edges: got %0d/%0d/%0d required 0/64/0", edges1[0] - e[0], edges1[1] - e[1], edges1[2] - e[2]);
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < 32; i++) exp_q.push_back({1'b1, body[31 - i]});
    check_stream("write", 64);
  endtask

  task automatic test_read();
    int t_acc, t_rsp;
    bit ok1, ok2;
    logic [13:0] body = 14'b01_10_11111_00010;
    rx1_word = 16'h0007;
    drive_cmd(0, 2'd2, 1'b0, 5'h1F, 5'h02, 16'h0000, t_acc, ok1);
    repeat (200) @(negedge clk);
    total++;
    if (busy1 !== 3'b100) begin
      bad++; $display("FAIL read_busy: got %b required 100", busy1);
    end
    wait_rsp(0, t_rsp, ok2);
    total++;
    if (!(ok1 && ok2) || (t_rsp - t_acc) != 513) begin
      bad++; $display("FAIL read_latency: got %0d (ok %b%b) required 513", t_rsp - t_acc, ok1, ok2);
    end
    total++;
    if ({s_ch, s_err, s_rd} !== {2'd2, 1'b0, 16'h0007}) begin
      bad++; $display("FAIL read_rsp: got %h required %h", {s_ch, s_err, s_rd}, {2'd2, 1'b0, 16'h0007});
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b1, body[13 - i]});
    check_stream("read", 46);
  endtask

  task automatic test_invalid();
    int t_acc, t_rsp, e[3];
    bit ok1, ok2;
    e = edges1;
    drive_cmd(0, 2'd3, 1'b0, 5'h01, 5'h01, 16'h0000, t_acc, ok1);
    wait_rsp(0, t_rsp, ok2);
    total++;
    if (!(ok1 && ok2) || (t_rsp - t_acc) != 1) begin
      bad++; $display("FAIL invalid_latency: got %0d (ok %b%b) required 1", t_rsp - t_acc, ok1, ok2);
    end
    total++;
    if ({s_ch, s_err, s_rd} !== {2'd3, 1'b1, 16'h0}) begin
      bad++; $display("FAIL invalid_rsp: got %h required %h", {s_ch, s_err, s_rd}, {2'd3, 1'b1, 16'h0});
    end
    repeat (20) @(negedge clk);
    total++;
    if (edges1[0] != e[0] || edges1[1] != e[1] || edges1[2] != e[2] || busy1 !== 3'b000) begin
      bad++; $display("FAIL invalid_no_bus: got edges %0d/%0d/%0d busy %b required 0/0/0 000",
                      edges1[0] - e[0], edges1[1] - e[1], edges1[2] - e[2], busy1);
    end
  endtask

  task automatic test_back_to_back();
    int t1, r1, t2, r2;
    bit ok1, ok2, ok3, ok4;
    logic [15:0] got;
    drive_cmd(0, 2'd0, 1'b1, 5'h01, 5'h04, 16'hA5A5, t1, ok1);
    wait_rsp(0, r1, ok2);
    total++;
    if ({mdc1, c1_ready} !== 4'b0000) begin
      bad++; $display("FAIL b2b_done_cycle: got mdc/ready %b required 0000", {mdc1, c1_ready});
    end
    drive_cmd(0, 2'd0, 1'b1, 5'h01, 5'h04, 16'h5A5A, t2, ok3);
    total++;
    if (!(ok1 && ok2 && ok3) || t2 != r1 + 1) begin
      bad++; $display("FAIL b2b_accept: got %0d required %0d", t2, r1 + 1);
    end
    wait_rsp(0, r2, ok4);
    total++;
    if (!ok4 || (r2 - t2) != 513) begin
      bad++; $display("FAIL b2b_latency: got %0d required 513", r2 - t2);
    end
    got = '0;
    for (int i = 48; i < 64 && i < cap1_q.size(); i++) got = {got[14:0], cap1_q[i][0]};
    total++;
    if (got !== 16'h5A5A) begin
      bad++; $display("FAIL b2b_data: got %h required 5a5a", got);
    end
  endtask

  task automatic test_reset_mid();
    int t_acc, c0, k, n0, ready_bad;
    bit ok1, hit;
    drive_cmd(0, 2'd0, 1'b1, 5'h02, 5'h03, 16'hFFFF, t_acc, ok1);
    hit = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      #1;
      if (cap1_q.size() == 21) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!(ok1 && hit)) begin
      bad++; $display("FAIL rstmid_reach_bit20: got %b required 1", ok1 && hit);
    end
    n0 = rsp_cnt1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mdc1, txe1, busy1, txd1, c1_ready} !== 13'b000_000_000_111_0) begin
      bad++; $display("FAIL rstmid_outputs: got %b required 0000000001110", {mdc1, txe1, busy1, txd1, c1_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    ready_bad = 0;
    do begin
      @(negedge clk);
      k = cyc - c0;
      if (c1_ready !== (k >= 16)) ready_bad++;
    end while (k < 16);
    total++;
    if (ready_bad != 0) begin
      bad++; $display("FAIL rstmid_regate: wrong cycles=%0d required 0", ready_bad);
    end
    total++;
    if (rsp_cnt1 != n0) begin
      bad++; $display("FAIL rstmid_no_rsp: got %0d responses required 0", rsp_cnt1 - n0);
    end
  endtask

  task automatic test_preamble0();
    int t_acc, mdc_bad, en_bad;
    bit ok1;
    logic [2:0] exp_mdc;
    rx2_word = 16'hBEEF;
    drive_cmd(1, 2'd0, 1'b0, 5'h01, 5'h01, 16'h0000, t_acc, ok1);
    mdc_bad = 0;
    en_bad = 0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      exp_mdc = {2'b00, (((k - 1) % 5) >= 2)};
      if (mdc2 !== exp_mdc || r2_valid !== 1'b0) mdc_bad++;
      if (txe2 !== {2'b00, (((k - 1) / 5) < 14)}) en_bad++;
    end
    total++;
    if (!ok1 || mdc_bad != 0) begin
      bad++; $display("FAIL p0_mdc_shape: wrong cycles=%0d (ok %b) required 0", mdc_bad, ok1);
    end
    total++;
    if (en_bad != 0) begin
      bad++; $display("FAIL p0_tx_en: wrong cycles=%0d required 0", en_bad);
    end
    @(negedge clk);
    total++;
    if ({r2_valid, r2_err, r2_ch, r2_rd} !== {1'b1, 1'b0, 2'd0, 16'hBEEF}) begin
      bad++; $display("FAIL p0_rsp_at_161: got %h required %h", {r2_valid, r2_err, r2_ch, r2_rd}, {1'b1, 1'b0, 2'd0, 16'hBEEF});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset_gate();
    test_write();
    test_read();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_preamble0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_multi_master.md
Name: mdio_multi_master

Overview:
- Parametrised Clause-22 MDIO master serving NUM_CHANNELS independent MDIO buses from one shared frame engine and one command/response interface.
- Replaces per-bus MDIO transceiver instances and ad-hoc MDC gating in the management subsystem.
- Adds a configurable preamble length, power-up MDC gating, invalid-channel error reporting and a per-channel busy vector.

Parameters:
- NUM_CHANNELS, 3, number of MDIO buses (1..16).
- CLK_DIV, 75, clk cycles per MDC period (>=4).
- PREAMBLE_BITS, 32, preamble ones before ST (0..32).
- GATE_CYCLES, 1048575, post-reset cycles with MDC held low and cmd_ready low (>=1).
- CHAN_BITS (localparam), max(1,$clog2(NUM_CHANNELS)).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command this cycle.
- cmd_channel  in  CHAN_BITS  target bus.
- cmd_write  in  1  1=write, 0=read.
- cmd_phy_addr  in  5  PHYAD.
- cmd_reg_addr  in  5  REGAD.
- cmd_wr_data  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_channel  out  CHAN_BITS  channel of the completed command.
- rsp_error  out  1  command had an out-of-range channel.
- rsp_rd_data  out  16  read data (0 for writes and errors).
- chan_busy  out  NUM_CHANNELS  per-channel frame in progress.
- mdc  out  NUM_CHANNELS  per-bus MDC.
- mdio_tx_data  out  NUM_CHANNELS  per-bus drive value.
- mdio_tx_en  out  NUM_CHANNELS  per-bus output enable.
- mdio_rx_data  in  NUM_CHANNELS  per-bus pad input, already synchronised.

Behaviour:
- All outputs are registered.
- Reset (asserted, including mid-frame) forces: cmd_ready=0, rsp_*=0, chan_busy=0, mdc=0, mdio_tx_data=1, mdio_tx_en=0, state=GATE, gate counter=0. No partial response is generated.
- States: GATE, IDLE, FRAME, DONE.
- GATE: counts GATE_CYCLES cycles, then enters IDLE. cmd_ready goes high on the first IDLE cycle.
- IDLE:
  - cmd_ready=1. Handshake is cmd_valid&cmd_ready; the command is latched.
  - cmd_ready drops the cycle after accept and stays low until the cycle after DONE.
  - If cmd_channel>=NUM_CHANNELS: go to DONE with rsp_error=1. No bus activity.
  - Otherwise go to FRAME, with chan_busy[ch]=1, bit index=0 and divider=0.
- FRAME:
  - Frame length F = PREAMBLE_BITS+32 bits, MSB-first.
  - Bit order: preamble 1s; ST=01; OP=01 for write, 10 for read; PHYAD[4:0]; REGAD[4:0]; TA; DATA[15:0].
  - Divider counts 0..CLK_DIV-1 per bit. mdc[ch]=0 while divider<CLK_DIV/2 (floor), 1 otherwise.
  - The bit value updates when divider==0.
  - Write: tx_en=1 for all F bits; TA=10.
  - Read: tx_en=1 through REGAD (PREAMBLE_BITS+14 bits), then 0 for TA and DATA.
  - Read data is sampled from mdio_rx_data[ch] on the cycle the divider reaches CLK_DIV/2, for each DATA bit, and shifted in MSB-first.
  - Non-selected channels: mdc=0, tx_en=0, tx_data=1 at all times.
  - After the last bit's final divider cycle: go to DONE with tx_en=0, mdc=0 and chan_busy cleared.
- DONE: rsp_valid=1 for exactly one cycle, with rsp_channel and rsp_rd_data (read) or 0 (write/error). Then IDLE.
- Latency:
  - Valid channel: accept at cycle T gives rsp_valid at T+1+F*CLK_DIV.
  - Invalid channel: accept at T gives rsp_valid at T+1.
- Back-to-back commands: the earliest next accept is the cycle after rsp_valid. Minimum one idle cycle between frames, with MDC low.
- cmd_* inputs are ignored while cmd_ready=0.

Test Plan:
- Gate: GATE_CYCLES=16, cmd_valid held high from reset release -> cmd_ready first high at cycle 16; mdc all 0 before that; accept on cycle 16.
- Write: CLK_DIV=8, ch1, phy=5'h03, reg=5'h00, data=16'h1140 -> ch1 serial stream 32×1,01,01,00011,00000,10,0001000101000000; tx_en high for 64 bits; ch0/ch2 mdc flat; rsp_valid at T+513, rsp_rd_data=0.
- Read: ch2, phy=5'h1F, reg=5'h02, bus model returns 16'h0007 -> tx_en low from bit 46; rsp_rd_data=16'h0007; rsp_channel=2; chan_busy=3'b100 during the frame.
- Invalid channel: NUM_CHANNELS=3, cmd_channel=3 -> rsp_valid at T+1 with rsp_error=1; no mdc edges on any bus.
- Reset mid-frame: assert rst_n=0 at bit 20 -> same-cycle mdc=0, tx_en=0, chan_busy=0; no rsp_valid; GATE re-entered.
- PREAMBLE_BITS=0, CLK_DIV=5: read -> 32-bit frame; MDC low 2 / high 3 cycles; rsp_valid at T+161.
